mem_arbiter: RTL and testbench

Single-port memory arbiter and access sequencer that lets the instruction-fetch path and the load/store path of the core share one unified memory. It accepts at most one access at a time, drives the memory port, counts the fixed memory latency, and returns read data and a completion strobe to the requester that owns the access. It also raises `stall` so the PC and register-file write-back hold while an access is pending.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter and access sequencer for fetch and load/store paths
// Optional build macro MEM_ARBITER_RR_EN: round-robin arbitration instead of data-over-fetch priority.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_mask,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_mask,
    input  logic [31:0]       mem_rdata,
    output logic              stall
);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_WAIT  = 1'b1;
    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    logic [0:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       owner_q, owner_d;
    logic       we_q, we_d;
    logic       win_d, win_i;
    logic       idle, resp;

    assign idle = (state_q == S_IDLE);
    assign resp = (state_q == S_WAIT) && (cnt_q == 4'd1);

`ifdef MEM_ARBITER_RR_EN
    // last_q: 0 = fetch served last, 1 = data served last
    logic last_q, last_d;

    always_comb begin
        win_d = 1'b0;
        win_i = 1'b0;
        if (idle) begin
            if (d_req && if_req) begin
                win_d = ~last_q;
                win_i = last_q;
            end else begin
                win_d = d_req;
                win_i = if_req;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (win_d || win_i) begin
            last_d = win_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        win_d = idle && d_req;
        win_i = idle && if_req && !d_req;
    end
`endif

    always_comb begin
        if_gnt    = win_i;
        d_gnt     = win_d;
        mem_en    = win_i || win_d;
        mem_we    = win_d && d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_mask  = 4'h0;
        if (win_d) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_mask  = d_we ? d_mask : 4'h0;
        end else if (win_i) begin
            mem_addr = if_addr;
        end
        stall     = !idle || (if_req && !win_i) || (d_req && !win_d);
        if_rvalid = resp && !owner_q;
        d_rvalid  = resp && owner_q;
        if_rdata  = if_rvalid ? mem_rdata : 32'h0;
        d_rdata   = (d_rvalid && !we_q) ? mem_rdata : 32'h0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        we_d    = we_q;
        if (idle) begin
            if (win_d || win_i) begin
                state_d = S_WAIT;
                cnt_d   = LAT_CNT;
                owner_d = win_d;
                we_d    = win_d && d_we;
            end
        end else if (cnt_q > 4'd1) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            we_q    <= we_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter at LATENCY 1, 3 and 4
// Honours MEM_ARBITER_RR_EN when the build defines it.
module tb_mem_arbiter;
    localparam int NDUT = 3;
`ifdef MEM_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        if_req    [NDUT];
    logic [31:0] if_addr   [NDUT];
    logic        if_gnt    [NDUT];
    logic        if_rvalid [NDUT];
    logic [31:0] if_rdata  [NDUT];
    logic        d_req     [NDUT];
    logic        d_we      [NDUT];
    logic [31:0] d_addr    [NDUT];
    logic [31:0] d_wdata   [NDUT];
    logic [3:0]  d_mask    [NDUT];
    logic        d_gnt     [NDUT];
    logic        d_rvalid  [NDUT];
    logic [31:0] d_rdata   [NDUT];
    logic        mem_en    [NDUT];
    logic        mem_we    [NDUT];
    logic [31:0] mem_addr  [NDUT];
    logic [31:0] mem_wdata [NDUT];
    logic [3:0]  mem_mask  [NDUT];
    logic [31:0] mem_rdata [NDUT];
    logic        stall     [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_arbiter #(
            .ADDR_W (32),
            .LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 4))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .if_req   (if_req[g]),
            .if_addr  (if_addr[g]),
            .if_gnt   (if_gnt[g]),
            .if_rvalid(if_rvalid[g]),
            .if_rdata (if_rdata[g]),
            .d_req    (d_req[g]),
            .d_we     (d_we[g]),
            .d_addr   (d_addr[g]),
            .d_wdata  (d_wdata[g]),
            .d_mask   (d_mask[g]),
            .d_gnt    (d_gnt[g]),
            .d_rvalid (d_rvalid[g]),
            .d_rdata  (d_rdata[g]),
            .mem_en   (mem_en[g]),
            .mem_we   (mem_we[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_mask (mem_mask[g]),
            .mem_rdata(mem_rdata[g]),
            .stall    (stall[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;
    int n;
    bit hold;
    bit rnd_en;

    // Transaction-level reference: an access granted at cycle g occupies the port
    // until g+LAT and responds exactly at g+LAT.
    int          busy_until [NDUT];
    int          resp_at    [NDUT];
    logic        own        [NDUT];
    logic        rwe        [NDUT];
    logic        last       [NDUT];
    logic [31:0] raddr      [NDUT];
    logic        wd         [NDUT];
    logic        wi         [NDUT];

    function automatic int lat(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h100) ? 32'h00500093 : ((a * 32'h9E3779B1) ^ 32'h5A5A5A5A);
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d cyc=%0d observed=%h expected=%h", tag, k, n, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            busy_until[k] = 0;
            resp_at[k]    = -1;
            own[k]        = 1'b0;
            rwe[k]        = 1'b0;
            last[k]       = 1'b0;
            raddr[k]      = 32'h0;
            wd[k]         = 1'b0;
            wi[k]         = 1'b0;
        end
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < NDUT; k++) begin
            if_req[k] = 1'b0;
            d_req[k]  = 1'b0;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            bit          idle_e;
            bit          resp_e;
            logic [31:0] ea;
            idle_e = (n >= busy_until[k]);
            resp_e = !idle_e && (n == resp_at[k]);
            wd[k]  = 1'b0;
            wi[k]  = 1'b0;
            if (idle_e) begin
                if (d_req[k] && if_req[k]) begin
                    if (RR && last[k]) wi[k] = 1'b1;
                    else wd[k] = 1'b1;
                end else begin
                    wd[k] = d_req[k];
                    wi[k] = if_req[k];
                end
            end
            chk("if_gnt", k, 32'(if_gnt[k]), 32'(wi[k]));
            chk("d_gnt", k, 32'(d_gnt[k]), 32'(wd[k]));
            chk("mem_en", k, 32'(mem_en[k]), 32'(wd[k] || wi[k]));
            chk("stall", k, 32'(stall[k]),
                32'(!idle_e || (if_req[k] && !wi[k]) || (d_req[k] && !wd[k])));
            if (idle_e) begin
                ea = wd[k] ? d_addr[k] : (wi[k] ? if_addr[k] : 32'h0);
                chk("mem_addr", k, mem_addr[k], ea);
                chk("mem_we", k, 32'(mem_we[k]), 32'(wd[k] && d_we[k]));
                chk("mem_mask", k, 32'(mem_mask[k]), (wd[k] && d_we[k]) ? 32'(d_mask[k]) : 32'h0);
                if (!(wd[k] || wi[k])) chk("mem_wdata_idle", k, mem_wdata[k], 32'h0);
                if (wd[k] && d_we[k]) chk("mem_wdata", k, mem_wdata[k], d_wdata[k]);
            end
            chk("if_rvalid", k, 32'(if_rvalid[k]), 32'(resp_e && !own[k]));
            chk("d_rvalid", k, 32'(d_rvalid[k]), 32'(resp_e && own[k]));
            chk("if_rdata", k, if_rdata[k], (resp_e && !own[k]) ? memf(raddr[k]) : 32'h0);
            chk("d_rdata", k, d_rdata[k], (resp_e && own[k] && !rwe[k]) ? memf(raddr[k]) : 32'h0);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            if (!rst && (wd[k] || wi[k])) begin
                busy_until[k] = n + lat(k) + 1;
                resp_at[k]    = n + lat(k);
                own[k]        = wd[k];
                rwe[k]        = wd[k] && d_we[k];
                raddr[k]      = wd[k] ? d_addr[k] : if_addr[k];
                last[k]       = wd[k];
                if (!hold) begin
                    if (wd[k]) d_req[k] = 1'b0;
                    if (wi[k]) if_req[k] = 1'b0;
                end
            end
        end
        if (rst) model_reset();
        n++;
        if (rnd_en) begin
            for (int k = 0; k < NDUT; k++) begin
                if (!if_req[k] && ($urandom % 4 == 0)) begin
                    if_req[k]  = 1'b1;
                    if_addr[k] = $urandom & 32'hFFFF_FFFC;
                end else if (if_req[k] && ($urandom % 16 == 0)) begin
                    if_req[k] = 1'b0;
                end
                if (!d_req[k] && ($urandom % 3 == 0)) begin
                    d_req[k]   = 1'b1;
                    d_we[k]    = 1'($urandom % 2);
                    d_addr[k]  = $urandom;
                    d_wdata[k] = $urandom;
                    d_mask[k]  = 4'($urandom);
                end else if (d_req[k] && ($urandom % 16 == 0)) begin
                    d_req[k] = 1'b0;
                end
            end
        end
        for (int k = 0; k < NDUT; k++) begin
            mem_rdata[k] = (n == resp_at[k]) ? memf(raddr[k]) : $urandom;
        end
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            sample();
            advance();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_reqs();
        model_reset();
        sample();
        advance();
        rst = 1'b0;
    endtask

    task automatic issue_if(input logic [31:0] a);
        for (int k = 0; k < NDUT; k++) begin
            if_req[k]  = 1'b1;
            if_addr[k] = a;
        end
    endtask

    task automatic issue_d(input logic we, input logic [31:0] a, input logic [31:0] wdat, input logic [3:0] m);
        for (int k = 0; k < NDUT; k++) begin
            d_req[k]   = 1'b1;
            d_we[k]    = we;
            d_addr[k]  = a;
            d_wdata[k] = wdat;
            d_mask[k]  = m;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        n        = 0;
        hold     = 1'b0;
        rnd_en   = 1'b0;
        rst      = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            if_addr[k]   = 32'h0;
            d_we[k]      = 1'b0;
            d_addr[k]    = 32'h0;
            d_wdata[k]   = 32'h0;
            d_mask[k]    = 4'h0;
            mem_rdata[k] = 32'h0;
        end
        clear_reqs();
        model_reset();

        sample();
        chk("rst_stall", 0, 32'(stall[0]), 32'h0);
        chk("rst_mem_en", 2, 32'(mem_en[2]), 32'h0);
        advance();
        rst = 1'b0;
        run(2);

        // single fetch, LATENCY 1
        issue_if(32'h100);
        sample();
        chk("f_if_gnt", 0, 32'(if_gnt[0]), 32'h1);
        chk("f_mem_en", 0, 32'(mem_en[0]), 32'h1);
        advance();
        sample();
        chk("f_if_rvalid", 0, 32'(if_rvalid[0]), 32'h1);
        chk("f_if_rdata", 0, if_rdata[0], 32'h00500093);
        advance();
        sample();
        chk("f_stall_low", 0, 32'(stall[0]), 32'h0);
        advance();
        run(6);

        // store, LATENCY 3
        issue_d(1'b1, 32'h2000, 32'hDEADBEEF, 4'hF);
        sample();
        chk("st_mem_we", 1, 32'(mem_we[1]), 32'h1);
        chk("st_mem_mask", 1, 32'(mem_mask[1]), 32'hF);
        advance();
        for (int i = 1; i <= 3; i++) begin
            sample();
            chk("st_stall", 1, 32'(stall[1]), 32'h1);
            chk("st_d_rvalid", 1, 32'(d_rvalid[1]), 32'(i == 3));
            chk("st_d_rdata", 1, d_rdata[1], 32'h0);
            advance();
        end
        run(6);

        // simultaneous requests, LATENCY 1, pointer fresh from reset
        do_reset();
        issue_if(32'h40);
        issue_d(1'b0, 32'h3000, 32'h0, 4'h0);
        for (int c = 0; c < 4; c++) begin
            sample();
            chk("sim_d_gnt", 0, 32'(d_gnt[0]), 32'(c == 0));
            chk("sim_if_gnt", 0, 32'(if_gnt[0]), 32'(c == 2));
            chk("sim_if_rvalid", 0, 32'(if_rvalid[0]), 32'(c == 3));
            advance();
        end
        run(6);

        // both requests held across four grants
        do_reset();
        hold = 1'b1;
        issue_if(32'h80);
        issue_d(1'b0, 32'h3100, 32'h0, 4'h0);
        for (int c = 0; c < 8; c++) begin
            sample();
            chk("hold_mem_en", 0, 32'(mem_en[0]), 32'(c % 2 == 0));
            chk("hold_d_gnt", 0, 32'(d_gnt[0]), 32'((c % 2 == 0) && (!RR || ((c / 2) % 2 == 0))));
            chk("hold_if_gnt", 0, 32'(if_gnt[0]), 32'((c % 2 == 0) && RR && ((c / 2) % 2 == 1)));
            advance();
        end
        hold = 1'b0;
        clear_reqs();
        run(6);

        // reset while a LATENCY 4 load is outstanding
        issue_d(1'b0, 32'h4000, 32'h0, 4'h0);
        sample();
        chk("rw_d_gnt", 2, 32'(d_gnt[2]), 32'h1);
        advance();
        run(1);
        rst = 1'b1;
        clear_reqs();
        model_reset();
        sample();
        chk("rw_in_rst_stall", 2, 32'(stall[2]), 32'h0);
        advance();
        rst = 1'b0;
        run(1);
        sample();
        chk("rw_no_rvalid", 2, 32'(d_rvalid[2]), 32'h0);
        advance();
        issue_d(1'b0, 32'h4004, 32'h0, 4'h0);
        sample();
        chk("rw_regrant", 2, 32'(d_gnt[2]), 32'h1);
        advance();
        run(6);

        // data request arriving during a fetch's WAIT, LATENCY 4
        issue_if(32'h500);
        sample();
        chk("dw_if_gnt", 2, 32'(if_gnt[2]), 32'h1);
        advance();
        issue_d(1'b0, 32'h600, 32'h0, 4'h0);
        for (int i = 1; i <= 4; i++) begin
            sample();
            chk("dw_no_d_gnt", 2, 32'(d_gnt[2]), 32'h0);
            chk("dw_stall", 2, 32'(stall[2]), 32'h1);
            chk("dw_if_rvalid", 2, 32'(if_rvalid[2]), 32'(i == 4));
            advance();
        end
        sample();
        chk("dw_d_gnt", 2, 32'(d_gnt[2]), 32'h1);
        advance();
        run(6);

        // randomized traffic with occasional resets
        rnd_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 400 == 0) begin
                do_reset();
            end else begin
                sample();
                advance();
            end
        end
        rnd_en = 1'b0;
        clear_reqs();
        run(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
